// File: rtl/cb_cfg_sequencer_if.sv
// Config request / config bus interface for cb_cfg_sequencer.
// Contents:
//   req_valid, req_ready, req_addr, req_data  - request handshake from the config master
//   config_addr, config_data, config_en       - replayed write bus toward the cb config ports
//   idle, done                                - sequencer status
// Modports:
//   master - the requesting side; it drives the request and observes the bus and status.
//   slave  - the sequencer side; it accepts requests and drives the bus and status.

interface cb_cfg_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [31:0] config_addr;
  logic [31:0] config_data;
  logic        config_en;
  logic        idle;
  logic        done;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, config_addr, config_data, config_en, idle, done
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, config_addr, config_data, config_en, idle, done
  );
endinterface

// File: rtl/cb_cfg_sequencer.sv
// Configuration sequencer for connection-box tiles.
// Config write requests are buffered in a small FIFO. Each one is replayed onto the shared
// config bus with config_en held for EN_CYCLES edges, followed by SETTLE_CYCLES idle cycles.
// Ports:
//   clk          - clock, rising edge
//   reset        - synchronous, active-high reset
//   bus          - cb_cfg_sequencer_if.slave (request handshake, config bus, idle/done status)
//   write_count  - [15:0] saturating count of issued writes (only with CFG_WRITE_COUNT_EN)
// Optional feature: define CFG_WRITE_COUNT_EN to add the write_count output.

module cb_cfg_sequencer #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned EN_CYCLES     = 2,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  cb_cfg_sequencer_if.slave        bus
`ifdef CFG_WRITE_COUNT_EN
  ,
  output logic [15:0]              write_count
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;
  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [EW-1:0] EnLoad    = EW'(EN_CYCLES - 1);
  // The reload value is only used when a settle phase exists.
  localparam logic [SW-1:0] SetLoad   = (SETTLE_CYCLES > 0) ? SW'(SETTLE_CYCLES - 1) : '0;
  localparam bit            HasSettle = (SETTLE_CYCLES > 0);
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;

  // FIFO storage and pointers; DEPTH is a power of two so pointers wrap naturally.
  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full, empty, push, pop;

  logic [1:0]    state_q, state_d;
  logic          en_q, en_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [EW-1:0] en_cnt_q, en_cnt_d;
  logic [SW-1:0] set_cnt_q, set_cnt_d;
  logic          done_q, done_d;

  assign full  = (count_q == FullCount);
  assign empty = (count_q == '0);
  // Ready depends only on registered occupancy, so a full FIFO stays not-ready even when popping.
  assign push  = bus.req_valid && !full;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.req_addr, bus.req_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    addr_d    = addr_q;
    data_d    = data_q;
    en_cnt_d  = en_cnt_q;
    set_cnt_d = set_cnt_q;
    pop       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop              = 1'b1;
          {addr_d, data_d} = mem_q[rd_ptr_q];
          en_d             = 1'b1;
          en_cnt_d         = EnLoad;
          state_d          = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (en_cnt_q == '0) begin
          en_d = 1'b0;
          if (HasSettle) begin
            set_cnt_d = SetLoad;
            state_d   = ST_SETTLE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          en_cnt_d = en_cnt_q - 1'b1;
        end
      end
      ST_SETTLE: begin
        en_d = 1'b0;
        if (set_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          set_cnt_d = set_cnt_q - 1'b1;
        end
      end
      default: begin
        en_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pulse when the last queued write has finished: returning to IDLE with nothing left to pop.
  assign done_d = (state_d == ST_IDLE) && (state_q != ST_IDLE) && (count_d == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      en_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      en_cnt_q  <= '0;
      set_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      en_cnt_q  <= en_cnt_d;
      set_cnt_q <= set_cnt_d;
      done_q    <= done_d;
    end
  end

  assign bus.req_ready   = !full;
  assign bus.config_addr = addr_q;
  assign bus.config_data = data_q;
  assign bus.config_en   = en_q;
  assign bus.idle        = empty && (state_q == ST_IDLE);
  assign bus.done        = done_q;

`ifdef CFG_WRITE_COUNT_EN
  logic [15:0] write_count_q;

  // Counts IDLE->ISSUE transitions, which coincide exactly with pops.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_count_q <= '0;
    end else if (pop && (write_count_q != 16'hFFFF)) begin
      write_count_q <= write_count_q + 16'd1;
    end
  end

  assign write_count = write_count_q;
`endif

endmodule
